trap_ctrl: RTL and testbench
============================

TRAP_CTRL -- requirements
Module: trap_ctrl

Interface
REQ-001 SHALL have parameter VECTOR, default 32'h00000000, the reset value of mevect.
REQ-002 SHALL have parameter NUM_IRQ, default 4, the number of external interrupt lines (legal range 1..16).
REQ-003 SHALL have port I_clk  input  1  clock; all state updates on the rising edge.
REQ-004 SHALL have port I_rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have ports I_ecall, I_ebreak, I_illegalinst  input  1 each  synchronous exception requests.
REQ-006 SHALL have port I_irq  input  NUM_IRQ  level-sensitive external interrupt lines.
REQ-007 SHALL have port I_mret  input  1  MRET executing this cycle.
REQ-008 SHALL have port I_pc  input  32  PC of the current instruction.
REQ-009 SHALL have ports I_csrwen  input  1, I_csraddr  input  12, I_wdata  input  32  CSR write strobe, address and data.
REQ-010 SHALL have port O_csrdata  output  32  combinational CSR read data.
REQ-011 SHALL have ports O_trap  output  1, O_epcreturn  output  32, O_evect  output  32  PC redirect controls.

Function
REQ-012 SHALL map these CSRs (RW address / RO alias): mstatus 7C0/FC0 {MPIE[1],MIE[0]}; mcause 7C1/FC1 {INT[31],CODE[4:0]}; mepc 7C2/FC2; mevect 7C3/FC3, with bit0 = MODE (0 direct, 1 vectored); mie 7C4/FC4 [NUM_IRQ-1:0]; mip 7C5/FC5 [NUM_IRQ-1:0].
REQ-013 SHALL return 32'hFFFFFFFF on reads of unmapped addresses, and zero in all unimplemented bits.
REQ-014 SHALL set mip[i] on any cycle where I_irq[i]=1; a mip[i] bit SHALL stay set until a CSR write to 7C5 with I_wdata[i]=1 clears it (write-1-to-clear). If set and clear coincide, set wins.
REQ-015 SHALL treat an interrupt as eligible when MIE=1 and (mip & mie) != 0; lowest index wins; cause = {1, 16+i}.
REQ-016 SHALL prioritise events per cycle as: exception > interrupt > mret > CSR write. Only one SHALL take effect per cycle.
REQ-017 SHALL use exception cause codes: illegal 2 (highest), ebreak 3, ecall 11 (lowest); INT=0 for all of them.
REQ-018 SHALL, on trap entry, perform: mepc<=I_pc, mcause<=cause, MPIE<=MIE, MIE<=0, O_trap<=1 next cycle.
REQ-019 SHALL assert O_trap for exactly one cycle, one cycle after the trap cycle; O_evect and O_epcreturn SHALL be valid while O_trap is high.
REQ-020 SHALL drive O_evect = mevect & ~3 when MODE=0 or INT=0; otherwise it SHALL drive (mevect & ~3) + 4*CODE.
REQ-021 SHALL drive O_epcreturn = mepc+4 when INT=0, and mepc when INT=1.
REQ-022 SHALL, on MRET: MIE<=MPIE, MPIE<=1.
REQ-023 SHALL ignore a CSR write that loses to a higher-priority event; the write is dropped, not deferred.
REQ-024 SHALL not clear a mip bit because its interrupt was taken; software clears it.

Reset
REQ-025 SHALL, on I_rst, drive mstatus=0, mcause=0, mepc=0, mevect=VECTOR, mie=0, mip=0, O_trap=0; reset SHALL override all events in the same cycle.
REQ-026 SHALL take I_rst asserted while O_trap=1 as dropping O_trap the following cycle.

Configuration
REQ-027 SHALL, with TRAP_CTRL_TIMER_EN defined, add a 32-bit mtime (7C6/FC6, RW) incrementing every cycle with wrap, mtimecmp (7C7/FC7, RW, reset FFFFFFFF), mstatus bit2 MTIE, and a timer interrupt of cause {1,7} when MIE & MTIE & (mtime >= mtimecmp). This interrupt SHALL rank below all external lines.
REQ-028 SHALL, without TRAP_CTRL_TIMER_EN, make 7C6/7C7 unmapped, read mstatus bit2 as 0, and keep no timer logic.

Structure
REQ-029 SHALL define CSR addresses, cause codes and mstatus bit indices in shared package trap_pkg.
REQ-030 SHALL use one sub-module, irq_prio_enc (NUM_IRQ-wide lowest-index priority encoder with valid output).

Verification
REQ-031 Reset, then I_illegalinst=1 with I_pc=0x100 -> mcause=0x2, mepc=0x100, O_trap=1 next cycle for one cycle, O_epcreturn=0x104, O_evect=VECTOR.
REQ-032 MIE=1, mie=0xF, I_irq=4'b0110 pulsed one cycle, MODE=1, mevect=0x200 -> cause=0x80000011, O_evect=0x244, O_epcreturn=mepc, mip=4'b0110 retained.
REQ-033 I_ecall and I_irq[0] together with MIE=1 -> ecall taken (mcause=0xB), mip[0] stays set, interrupt taken after MRET.
REQ-034 Write 0x2 to 7C5 in the same cycle I_irq[1]=1 -> mip[1] remains 1; next write with I_irq low -> cleared.
REQ-035 I_csrwen to 7C2 in the same cycle as I_ebreak -> mepc=I_pc, not I_wdata; read 0x7FF -> 0xFFFFFFFF.
REQ-036 TRAP_CTRL_TIMER_EN: mtimecmp=10, MTIE=MIE=1 from reset -> trap with mcause=0x80000007 when mtime reaches 10.

Source files
------------

// File: rtl/trap_pkg.sv
// -----------------------------------------------------------------------------
// trap_pkg
// Shared definitions for the machine-mode trap controller: CSR addresses,
// trap cause codes, mstatus bit positions and small decode helpers.
// Ports: none (package).
// Optional feature macro: TRAP_CTRL_TIMER_EN (adds the mtime/mtimecmp CSRs).
// -----------------------------------------------------------------------------
package trap_pkg;

    // Read/write CSR addresses; the read-only alias of each is the same
    // address with bit 11 set (0x7Cx -> 0xFCx).
    localparam logic [11:0] CSR_MSTATUS  = 12'h7C0;
    localparam logic [11:0] CSR_MCAUSE   = 12'h7C1;
    localparam logic [11:0] CSR_MEPC     = 12'h7C2;
    localparam logic [11:0] CSR_MEVECT   = 12'h7C3;
    localparam logic [11:0] CSR_MIE      = 12'h7C4;
    localparam logic [11:0] CSR_MIP      = 12'h7C5;
    localparam logic [11:0] CSR_MTIME    = 12'h7C6;
    localparam logic [11:0] CSR_MTIMECMP = 12'h7C7;
    localparam logic [11:0] CSR_RO_ALIAS = 12'h800;

    // Trap cause codes (mcause[4:0]).
    localparam logic [4:0] CAUSE_ILLEGAL  = 5'd2;
    localparam logic [4:0] CAUSE_EBREAK   = 5'd3;
    localparam logic [4:0] CAUSE_ECALL    = 5'd11;
    localparam logic [4:0] CAUSE_TIMER    = 5'd7;
    localparam logic [4:0] CAUSE_IRQ_BASE = 5'd16;

    // mstatus / mcause bit positions.
    localparam int MSTATUS_MIE_BIT  = 0;
    localparam int MSTATUS_MPIE_BIT = 1;
    localparam int MSTATUS_MTIE_BIT = 2;
    localparam int MCAUSE_INT_BIT   = 31;

    // The single event that takes effect in a cycle, highest priority first.
    typedef enum logic [2:0] {
        EV_NONE,
        EV_EXC,
        EV_INT,
        EV_MRET,
        EV_CSRW
    } trap_event_e;

    // True when addr selects the CSR at base through either its RW address
    // or its read-only alias.
    function automatic logic csr_hit(input logic [11:0] addr, input logic [11:0] base);
        return (addr == base) || (addr == (base | CSR_RO_ALIAS));
    endfunction

    // Exception cause when several exception requests arrive together:
    // illegal instruction beats ebreak, which beats ecall.
    function automatic logic [4:0] exc_code(input logic illegal, input logic ebreak);
        if (illegal) begin
            return CAUSE_ILLEGAL;
        end else if (ebreak) begin
            return CAUSE_EBREAK;
        end
        return CAUSE_ECALL;
    endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// -----------------------------------------------------------------------------
// irq_prio_enc
// Lowest-index-wins priority encoder for the pending-and-enabled interrupt
// vector.
// Ports:
//   I_req   [N-1:0]  request vector
//   O_valid          at least one request bit set
//   O_idx   [3:0]    index of the lowest set request bit (0 when none)
// -----------------------------------------------------------------------------
module irq_prio_enc #(
    parameter int N = 4
) (
    input  logic [N-1:0] I_req,
    output logic         O_valid,
    output logic [3:0]   O_idx
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        O_valid = 1'b0;
        O_idx   = 4'd0;
        for (int i = N - 1; i >= 0; i--) begin
            if (I_req[i]) begin
                O_valid = 1'b1;
                O_idx   = 4'(i);
            end
        end
    end

endmodule

// File: rtl/trap_ctrl.sv
// -----------------------------------------------------------------------------
// trap_ctrl
// Machine-mode trap controller: exception/interrupt entry, MRET, and the
// associated CSRs (mstatus, mcause, mepc, mevect, mie, mip).
// Optional feature macro: TRAP_CTRL_TIMER_EN adds mtime/mtimecmp, the
// mstatus MTIE bit and a timer interrupt ranked below all external lines.
// Ports:
//   I_clk, I_rst                  clock, synchronous active-high reset
//   I_ecall/I_ebreak/I_illegalinst exception requests
//   I_irq [NUM_IRQ-1:0]           level-sensitive interrupt lines
//   I_mret                        MRET executing this cycle
//   I_pc [31:0]                   PC of the current instruction
//   I_csrwen/I_csraddr/I_wdata    CSR write strobe, address, data
//   O_csrdata [31:0]              combinational CSR read data
//   O_trap                        one-cycle redirect pulse after trap entry
//   O_epcreturn/O_evect [31:0]    return PC and handler address
// -----------------------------------------------------------------------------
module trap_ctrl
    import trap_pkg::*;
#(
    parameter logic [31:0] VECTOR  = 32'h0000_0000,
    parameter int          NUM_IRQ = 4
) (
    input  logic               I_clk,
    input  logic               I_rst,
    input  logic               I_ecall,
    input  logic               I_ebreak,
    input  logic               I_illegalinst,
    input  logic [NUM_IRQ-1:0] I_irq,
    input  logic               I_mret,
    input  logic [31:0]        I_pc,
    input  logic               I_csrwen,
    input  logic [11:0]        I_csraddr,
    input  logic [31:0]        I_wdata,
    output logic [31:0]        O_csrdata,
    output logic               O_trap,
    output logic [31:0]        O_epcreturn,
    output logic [31:0]        O_evect
);

    logic               mstatus_mie_q,  mstatus_mie_d;
    logic               mstatus_mpie_q, mstatus_mpie_d;
    logic               mcause_int_q,   mcause_int_d;
    logic [4:0]         mcause_code_q,  mcause_code_d;
    logic [31:0]        mepc_q,         mepc_d;
    logic [31:0]        mevect_q,       mevect_d;
    logic [NUM_IRQ-1:0] mie_q,          mie_d;
    logic [NUM_IRQ-1:0] mip_q,          mip_d;
    logic               trap_q,         trap_d;

    logic               mtie_rd;
    logic               timer_hit;

`ifdef TRAP_CTRL_TIMER_EN
    logic               mstatus_mtie_q, mstatus_mtie_d;
    logic [31:0]        mtime_q,        mtime_d;
    logic [31:0]        mtimecmp_q,     mtimecmp_d;

    assign mtie_rd   = mstatus_mtie_q;
    assign timer_hit = mstatus_mtie_q && (mtime_q >= mtimecmp_q);
`else
    assign mtie_rd   = 1'b0;
    assign timer_hit = 1'b0;
`endif

    logic        enc_valid;
    logic [3:0]  enc_idx;

    // Interrupts are taken from the registered pending bits, so a line
    // raised this cycle becomes eligible on the next one.
    irq_prio_enc #(
        .N (NUM_IRQ)
    ) u_prio_enc (
        .I_req   (mip_q & mie_q),
        .O_valid (enc_valid),
        .O_idx   (enc_idx)
    );

    logic        exc_req;
    logic        int_req;
    trap_event_e ev;

    assign exc_req = I_ecall | I_ebreak | I_illegalinst;
    assign int_req = mstatus_mie_q & (enc_valid | timer_hit);

    always_comb begin
        ev = EV_NONE;
        if (exc_req) begin
            ev = EV_EXC;
        end else if (int_req) begin
            ev = EV_INT;
        end else if (I_mret) begin
            ev = EV_MRET;
        end else if (I_csrwen) begin
            ev = EV_CSRW;
        end
    end

    // Next-state for every CSR. Interrupt lines always set mip, independent
    // of which event wins; a winning mip write only clears bits whose line
    // is not asserted this cycle.
    always_comb begin
        mstatus_mie_d  = mstatus_mie_q;
        mstatus_mpie_d = mstatus_mpie_q;
        mcause_int_d   = mcause_int_q;
        mcause_code_d  = mcause_code_q;
        mepc_d         = mepc_q;
        mevect_d       = mevect_q;
        mie_d          = mie_q;
        mip_d          = mip_q | I_irq;
        trap_d         = 1'b0;
`ifdef TRAP_CTRL_TIMER_EN
        mstatus_mtie_d = mstatus_mtie_q;
        mtime_d        = mtime_q + 32'd1;
        mtimecmp_d     = mtimecmp_q;
`endif

        case (ev)
            EV_EXC: begin
                mepc_d         = I_pc;
                mcause_int_d   = 1'b0;
                mcause_code_d  = exc_code(I_illegalinst, I_ebreak);
                mstatus_mpie_d = mstatus_mie_q;
                mstatus_mie_d  = 1'b0;
                trap_d         = 1'b1;
            end
            EV_INT: begin
                mepc_d         = I_pc;
                mcause_int_d   = 1'b1;
                mcause_code_d  = enc_valid ? (CAUSE_IRQ_BASE + {1'b0, enc_idx}) : CAUSE_TIMER;
                mstatus_mpie_d = mstatus_mie_q;
                mstatus_mie_d  = 1'b0;
                trap_d         = 1'b1;
            end
            EV_MRET: begin
                mstatus_mie_d  = mstatus_mpie_q;
                mstatus_mpie_d = 1'b1;
            end
            EV_CSRW: begin
                // Only the RW addresses are writable; the aliases ignore writes.
                case (I_csraddr)
                    CSR_MSTATUS: begin
                        mstatus_mie_d  = I_wdata[MSTATUS_MIE_BIT];
                        mstatus_mpie_d = I_wdata[MSTATUS_MPIE_BIT];
`ifdef TRAP_CTRL_TIMER_EN
                        mstatus_mtie_d = I_wdata[MSTATUS_MTIE_BIT];
`endif
                    end
                    CSR_MCAUSE: begin
                        mcause_int_d  = I_wdata[MCAUSE_INT_BIT];
                        mcause_code_d = I_wdata[4:0];
                    end
                    CSR_MEPC:   mepc_d   = I_wdata;
                    CSR_MEVECT: mevect_d = I_wdata;
                    CSR_MIE:    mie_d    = I_wdata[NUM_IRQ-1:0];
                    CSR_MIP:    mip_d    = (mip_q & ~I_wdata[NUM_IRQ-1:0]) | I_irq;
`ifdef TRAP_CTRL_TIMER_EN
                    CSR_MTIME:    mtime_d    = I_wdata;
                    CSR_MTIMECMP: mtimecmp_d = I_wdata;
`endif
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    // State register; reset overrides every event in the same cycle.
    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            mstatus_mie_q  <= 1'b0;
            mstatus_mpie_q <= 1'b0;
            mcause_int_q   <= 1'b0;
            mcause_code_q  <= 5'd0;
            mepc_q         <= 32'd0;
            mevect_q       <= VECTOR;
            mie_q          <= '0;
            mip_q          <= '0;
            trap_q         <= 1'b0;
`ifdef TRAP_CTRL_TIMER_EN
            mstatus_mtie_q <= 1'b0;
            mtime_q        <= 32'd0;
            mtimecmp_q     <= 32'hFFFF_FFFF;
`endif
        end else begin
            mstatus_mie_q  <= mstatus_mie_d;
            mstatus_mpie_q <= mstatus_mpie_d;
            mcause_int_q   <= mcause_int_d;
            mcause_code_q  <= mcause_code_d;
            mepc_q         <= mepc_d;
            mevect_q       <= mevect_d;
            mie_q          <= mie_d;
            mip_q          <= mip_d;
            trap_q         <= trap_d;
`ifdef TRAP_CTRL_TIMER_EN
            mstatus_mtie_q <= mstatus_mtie_d;
            mtime_q        <= mtime_d;
            mtimecmp_q     <= mtimecmp_d;
`endif
        end
    end

    // Redirect outputs derive from the CSRs just written at trap entry, so
    // they are valid in the same cycle that O_trap is high.
    logic [31:0] evect_base;

    assign evect_base  = {mevect_q[31:2], 2'b00};
    assign O_trap      = trap_q;
    assign O_evect     = (mevect_q[0] && mcause_int_q) ? (evect_base + {25'd0, mcause_code_q, 2'b00})
                                                       : evect_base;
    assign O_epcreturn = mcause_int_q ? mepc_q : (mepc_q + 32'd4);

    // Combinational read mux; unmapped addresses read as all ones.
    always_comb begin
        O_csrdata = 32'hFFFF_FFFF;
        if (csr_hit(I_csraddr, CSR_MSTATUS)) begin
            O_csrdata = {29'd0, mtie_rd, mstatus_mpie_q, mstatus_mie_q};
        end else if (csr_hit(I_csraddr, CSR_MCAUSE)) begin
            O_csrdata = {mcause_int_q, 26'd0, mcause_code_q};
        end else if (csr_hit(I_csraddr, CSR_MEPC)) begin
            O_csrdata = mepc_q;
        end else if (csr_hit(I_csraddr, CSR_MEVECT)) begin
            O_csrdata = mevect_q;
        end else if (csr_hit(I_csraddr, CSR_MIE)) begin
            O_csrdata = {{(32 - NUM_IRQ){1'b0}}, mie_q};
        end else if (csr_hit(I_csraddr, CSR_MIP)) begin
            O_csrdata = {{(32 - NUM_IRQ){1'b0}}, mip_q};
        end
`ifdef TRAP_CTRL_TIMER_EN
        else if (csr_hit(I_csraddr, CSR_MTIME)) begin
            O_csrdata = mtime_q;
        end else if (csr_hit(I_csraddr, CSR_MTIMECMP)) begin
            O_csrdata = mtimecmp_q;
        end
`endif
    end

endmodule

// File: tb/tb_trap_ctrl.sv
// -----------------------------------------------------------------------------
// tb_trap_ctrl
// Directed self-checking bench for trap_ctrl. Each expected trap redirect
// (handler address, return PC) is queued when its stimulus is driven and
// compared when O_trap rises; CSR state is checked by direct reads.
// -----------------------------------------------------------------------------
module tb_trap_ctrl;

    localparam logic [31:0] TB_VECTOR = 32'h0000_0800;

    typedef struct packed {
        logic [31:0] vect;
        logic [31:0] epcRet;
    } trapExp_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        ecall, ebreak, illegalInst, mret, csrWen;
    logic [3:0]  irq;
    logic [31:0] pc, wdata;
    logic [11:0] csrAddr;
    logic [31:0] csrData, epcReturn, evect;
    logic        trap;

    trapExp_t    sb[$];
    int          checks = 0;
    int          errors = 0;

    always #5 clock = ~clock;

    trap_ctrl #(
        .VECTOR  (TB_VECTOR),
        .NUM_IRQ (4)
    ) dut (
        .I_clk         (clock),
        .I_rst         (reset),
        .I_ecall       (ecall),
        .I_ebreak      (ebreak),
        .I_illegalinst (illegalInst),
        .I_irq         (irq),
        .I_mret        (mret),
        .I_pc          (pc),
        .I_csrwen      (csrWen),
        .I_csraddr     (csrAddr),
        .I_wdata       (wdata),
        .O_csrdata     (csrData),
        .O_trap        (trap),
        .O_epcreturn   (epcReturn),
        .O_evect       (evect)
    );

    // Single comparison point: counts every check and reports failures.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // One-cycle CSR write.
    task automatic applyStimulus(input logic [11:0] addr, input logic [31:0] data);
        csrAddr = addr;
        wdata   = data;
        csrWen  = 1'b1;
        tick();
        csrWen  = 1'b0;
    endtask

    task automatic readCheck(input string tag, input logic [11:0] addr, input logic [31:0] expected);
        csrAddr = addr;
        #1;
        checkOutput(tag, csrData, expected);
    endtask

    task automatic expectTrap(input logic [31:0] v, input logic [31:0] e);
        trapExp_t t;
        t.vect   = v;
        t.epcRet = e;
        sb.push_back(t);
    endtask

    // Scoreboard consumer: every O_trap cycle must match a queued entry,
    // which also catches a pulse lasting more than one cycle.
    always @(negedge clock) begin
        if (trap === 1'b1) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_trap", {31'd0, trap}, 32'd0);
            end else begin : popBlk
                trapExp_t t;
                t = sb.pop_front();
                checkOutput("trap_evect", evect, t.vect);
                checkOutput("trap_epcreturn", epcReturn, t.epcRet);
            end
        end
    end

    initial begin
        reset = 1'b1; ecall = 1'b0; ebreak = 1'b0; illegalInst = 1'b0; mret = 1'b0;
        csrWen = 1'b0; irq = 4'd0; pc = 32'd0; wdata = 32'd0; csrAddr = 12'h7FF;
        tick();
        tick();
        reset = 1'b0;

        // Reset state.
        checkOutput("rst_trap", {31'd0, trap}, 32'd0);
        readCheck("rst_mstatus", 12'h7C0, 32'h0);
        readCheck("rst_mcause", 12'h7C1, 32'h0);
        readCheck("rst_mepc", 12'h7C2, 32'h0);
        readCheck("rst_mevect_alias", 12'hFC3, TB_VECTOR);
        readCheck("rst_mie", 12'h7C4, 32'h0);
        readCheck("rst_mip", 12'h7C5, 32'h0);

        // Illegal instruction from reset.
        expectTrap(TB_VECTOR, 32'h104);
        illegalInst = 1'b1; pc = 32'h100;
        tick();
        illegalInst = 1'b0;
        readCheck("ill_mcause", 12'h7C1, 32'h2);
        readCheck("ill_mepc", 12'h7C2, 32'h100);
        tick();
        checkOutput("ill_trap_one_cycle", {31'd0, trap}, 32'd0);

        // Vectored external interrupt, lowest index of 0110 wins.
        applyStimulus(12'h7C3, 32'h201);
        applyStimulus(12'h7C4, 32'hF);
        applyStimulus(12'h7C0, 32'h1);
        irq = 4'b0110; pc = 32'h300;
        tick();
        irq = 4'b0000; pc = 32'h304;
        expectTrap(32'h244, 32'h304);
        tick();
        readCheck("irq_mcause", 12'h7C1, 32'h8000_0011);
        readCheck("irq_mip_kept", 12'h7C5, 32'h6);
        readCheck("irq_mstatus", 12'h7C0, 32'h2);
        tick();

        // Software clears mip, then MRET restores MIE.
        applyStimulus(12'h7C5, 32'h6);
        readCheck("w1c_mip", 12'h7C5, 32'h0);
        mret = 1'b1;
        tick();
        mret = 1'b0;
        readCheck("mret_mstatus", 12'h7C0, 32'h3);

        // Exception beats a simultaneous interrupt; interrupt follows MRET.
        ecall = 1'b1; irq = 4'b0001; pc = 32'h400;
        expectTrap(32'h200, 32'h404);
        tick();
        ecall = 1'b0; irq = 4'b0000;
        readCheck("ecall_mcause", 12'h7C1, 32'hB);
        readCheck("ecall_mip0", 12'h7C5, 32'h1);
        tick();
        mret = 1'b1;
        tick();
        mret = 1'b0; pc = 32'h500;
        expectTrap(32'h240, 32'h500);
        tick();
        readCheck("irq0_mcause", 12'h7C1, 32'h8000_0010);
        readCheck("irq0_mepc", 12'h7C2, 32'h500);
        applyStimulus(12'h7C5, 32'h1);

        // Set wins over a coincident clear.
        irq = 4'b0010;
        applyStimulus(12'h7C5, 32'h2);
        irq = 4'b0000;
        readCheck("mip_set_wins", 12'h7C5, 32'h2);
        applyStimulus(12'h7C5, 32'h2);
        readCheck("mip_cleared", 12'h7C5, 32'h0);

        // A CSR write losing to ebreak is dropped.
        ebreak = 1'b1; pc = 32'h600;
        expectTrap(32'h200, 32'h604);
        applyStimulus(12'h7C2, 32'hDEAD_0000);
        ebreak = 1'b0;
        readCheck("ebreak_mepc", 12'h7C2, 32'h600);
        readCheck("ebreak_mcause", 12'h7C1, 32'h3);
        readCheck("unmapped", 12'h7FF, 32'hFFFF_FFFF);
        applyStimulus(12'hFC2, 32'h1234);
        readCheck("alias_ro", 12'hFC2, 32'h600);

        // Exception priority: ebreak beats ecall.
        ebreak = 1'b1; ecall = 1'b1; pc = 32'h700;
        expectTrap(32'h200, 32'h704);
        tick();
        ebreak = 1'b0; ecall = 1'b0;
        readCheck("prio_mcause", 12'h7C1, 32'h3);
        tick();

        // MRET beats a CSR write in the same cycle.
        mret = 1'b1;
        applyStimulus(12'h7C0, 32'h0);
        mret = 1'b0;
        readCheck("mret_over_csrw", 12'h7C0, 32'h2);

        // Reset while O_trap is high, with an ecall pending during reset.
        illegalInst = 1'b1; pc = 32'h800;
        expectTrap(32'h200, 32'h804);
        tick();
        illegalInst = 1'b0; reset = 1'b1; ecall = 1'b1;
        tick();
        checkOutput("rst_drops_trap", {31'd0, trap}, 32'd0);
        reset = 1'b0; ecall = 1'b0;
        tick();
        checkOutput("rst_blocks_ecall", {31'd0, trap}, 32'd0);
        readCheck("rst2_mevect", 12'h7C3, TB_VECTOR);
        readCheck("rst2_mcause", 12'h7C1, 32'h0);

`ifdef TRAP_CTRL_TIMER_EN
        // Timer interrupt once mtime reaches mtimecmp.
        pc = 32'h900;
        applyStimulus(12'h7C7, 32'd10);
        applyStimulus(12'h7C0, 32'h5);
        expectTrap(TB_VECTOR, 32'h900);
        for (int i = 0; i < 40 && sb.size() != 0; i++) tick();
        checkOutput("timer_trap_seen", 32'(sb.size()), 32'd0);
        readCheck("timer_mcause", 12'h7C1, 32'h8000_0007);
        readCheck("timer_mepc", 12'h7C2, 32'h900);
`else
        readCheck("no_mtime", 12'h7C6, 32'hFFFF_FFFF);
        readCheck("no_mtimecmp", 12'hFC7, 32'hFFFF_FFFF);
        applyStimulus(12'h7C0, 32'h7);
        readCheck("no_mtie", 12'h7C0, 32'h3);
`endif

        tick();
        checkOutput("sb_drained", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
